rf_wb_arbiter: RTL

//  Write-side master for the RF write port (RegWr/WrAddr/WrData). Merges the in-order

---
 rtl/rf_wb_arbiter_pkg.sv | 16 +
 rtl/rf_wb_arbiter_if.sv | 36 +++
 rtl/rf_wb_arbiter_fifo.sv | 53 +++++
 rtl/rf_wb_arbiter.sv | 95 +++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_wb_arbiter_pkg;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NREG  = 1 << AW;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ll_result_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Signal bundle between the pipeline/long-latency units and the RF write arbiter.
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic          WbRegWr;
  logic [AW-1:0] WbAddr;
  logic [DW-1:0] WbData;
  logic          LlIssue;
  logic [AW-1:0] LlIssueAddr;
  // Long-latency results: a result transfers on a rising edge where LlValid and
  // LlReady are both 1; LlReady never depends on LlValid in the same cycle.
  logic          LlValid;
  logic          LlReady;
  logic [AW-1:0] LlAddr;
  logic [DW-1:0] LlData;
  logic [AW-1:0] RsAddr;
  logic [AW-1:0] RtAddr;
  logic          RsPending;
  logic          RtPending;
  logic          RegWr;
  logic [AW-1:0] WrAddr;
  logic [DW-1:0] WrData;

  modport master (
    output WbRegWr, WbAddr, WbData, LlIssue, LlIssueAddr,
           LlValid, LlAddr, LlData, RsAddr, RtAddr,
    input  LlReady, RsPending, RtPending, RegWr, WrAddr, WrData
  );

  modport slave (
    input  WbRegWr, WbAddr, WbData, LlIssue, LlIssueAddr,
           LlValid, LlAddr, LlData, RsAddr, RtAddr,
    output LlReady, RsPending, RtPending, RegWr, WrAddr, WrData
  );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// In-order buffer for long-latency results; head is read straight from storage.
module wb_result_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = rf_wb_arbiter_pkg::DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ll_result_t din,
  input  logic       pop,
  output ll_result_t head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  ll_result_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// RF write-port arbiter: pipeline WB has priority, queued long-latency results
// fill idle slots, and a pending scoreboard flags registers still awaiting a result.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = rf_wb_arbiter_pkg::DEPTH
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);

  ll_result_t      head;
  ll_result_t      din;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            started;
  logic            ll_ready;
  logic            wb_win;
  logic            reg_wr;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Holds LlReady low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) started <= 1'b0;
    else      started <= 1'b1;
  end

  assign ll_ready = started && !full;
  assign push     = bus.LlValid && ll_ready;
  assign din      = '{addr: bus.LlAddr, data: bus.LlData};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign wb_win = bus.WbRegWr && (bus.WbAddr != REG_ZERO);

  // A WB write to $0 leaves the slot free, so the FIFO head may use it.
  always_comb begin
    reg_wr  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    pop     = 1'b0;
    if (rst) begin
      if (wb_win) begin
        reg_wr  = 1'b1;
        wr_addr = bus.WbAddr;
        wr_data = bus.WbData;
      end else if (!empty) begin
        pop = 1'b1;
        if (head.addr != REG_ZERO) begin
          reg_wr  = 1'b1;
          wr_addr = head.addr;
          wr_data = head.data;
        end
      end
    end
  end

  // Clear applied before set so a same-edge reissue keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (pop && (head.addr != REG_ZERO))
      pending_nxt[head.addr] = 1'b0;
    if (bus.LlIssue && (bus.LlIssueAddr != REG_ZERO))
      pending_nxt[bus.LlIssueAddr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  assign bus.LlReady   = ll_ready;
  assign bus.RegWr     = reg_wr;
  assign bus.WrAddr    = wr_addr;
  assign bus.WrData    = wr_data;
  assign bus.RsPending = (bus.RsAddr != REG_ZERO) && pending[bus.RsAddr];
  assign bus.RtPending = (bus.RtAddr != REG_ZERO) && pending[bus.RtAddr];

endmodule
